// File: rtl/key_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_capture_pkg
//  Description : Shared types and helpers for the one-hot key capture block.
//                - state_t    : capture FSM state encoding
//                - is_onehot  : true iff exactly one bit of a vector is set
//  Revision    : 1.0 - initial release
// ============================================================================
package key_capture_pkg;

    // Capture FSM states, 2-bit explicit encoding.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Widest key vector the helper below accepts. Narrower vectors are
    // zero-extended by the caller; zero-extension never changes whether a
    // vector is one-hot, so one fixed-width helper serves every WIDTH.
    localparam int unsigned ONEHOT_MAX_WIDTH = 64;

    // True iff exactly one bit is set. All-zero returns false.
    // Clearing the lowest set bit (vec & (vec - 1)) leaves zero only when a
    // single bit was set.
    function automatic logic is_onehot(input logic [ONEHOT_MAX_WIDTH-1:0] vec);
        logic                        nonzero;
        logic [ONEHOT_MAX_WIDTH-1:0] low_cleared;
        nonzero     = (vec != '0);
        low_cleared = vec & (vec - {{(ONEHOT_MAX_WIDTH-1){1'b0}}, 1'b1});
        return nonzero && (low_cleared == '0);
    endfunction

endpackage : key_capture_pkg
`default_nettype wire

// File: rtl/key_sync.sv
`default_nettype none
// ============================================================================
//  Module      : key_sync
//  Description : WIDTH-wide two-flop synchroniser for raw asynchronous key
//                lines. Each bit is synchronised independently; no attempt
//                is made to keep bits coherent with each other, the debounce
//                stage downstream absorbs any skew between bits.
//  Ports       : clk        - sampling clock
//                rst_n      - asynchronous active-low reset, flops clear to 0
//                i_key      - raw asynchronous key lines
//                o_key_sync - synchronised key lines (2-clock latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module key_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_key,
    output logic [WIDTH-1:0] o_key_sync
);

    // First stage may go metastable; second stage gives it a full clock to
    // resolve before anything downstream looks at it.
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = i_key;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_key_sync = sync_q;

endmodule : key_sync
`default_nettype wire

// File: rtl/onehot_key_capture.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_key_capture
//  Description : Upstream stage of an 8-to-3 encoder with enable. Synchronises
//                and debounces raw key lines, accepts a pattern only if it is
//                one-hot, presents it on w with active-low enable e until the
//                consumer acknowledges, then waits for all keys to be released
//                before arming for the next press.
//  Ports       : clk     - single clock, rising edge
//                rst_n   - asynchronous active-low reset
//                key_in  - raw asynchronous key lines, active-high
//                ack     - consumer has taken the code (honoured in HOLD only)
//                w       - captured one-hot word, zero when not valid
//                e       - active-low valid for w
//                err     - one-clock pulse when a multi-key pattern is rejected
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_key_capture
    import key_capture_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_in,
    input  logic             ack,
    output logic [WIDTH-1:0] w,
    output logic             e,
    output logic             err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // $clog2(DEBOUNCE_CYCLES) bits always hold DEBOUNCE_CYCLES-1, which is the
    // terminal value; the counter stops there so it never needs to wrap.
    localparam int              c_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_ks;

    key_sync #(
        .WIDTH (WIDTH)
    ) u_key_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_key      (key_in),
        .o_key_sync (w_ks)
    );

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   snap_q;
    logic [WIDTH-1:0]   snap_d;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_d;
    logic               e_q;
    logic               e_d;
    logic               err_q;
    logic               err_d;

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------
    logic                              w_ks_zero;
    logic                              w_ks_match;
    logic                              w_cnt_done;
    logic                              w_snap_onehot;
    logic [ONEHOT_MAX_WIDTH-1:0]       w_snap_ext;

    always_comb begin
        w_snap_ext    = ONEHOT_MAX_WIDTH'(snap_q);
        w_ks_zero     = (w_ks == '0);
        w_ks_match    = (w_ks == snap_q);
        w_cnt_done    = (cnt_q == c_CNT_LAST);
        w_snap_onehot = is_onehot(w_snap_ext);
    end

    // ------------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!w_ks_zero) begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (w_ks_zero) begin
                    state_d = ST_IDLE;
                end else if (w_ks_match && w_cnt_done) begin
                    state_d = w_snap_onehot ? ST_HOLD : ST_RELEASE;
                end
            end
            ST_HOLD: begin
                // Key activity is deliberately ignored here; only ack leaves.
                if (ack) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_ks_zero && w_cnt_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: output / datapath logic
    // ------------------------------------------------------------------------
    // w/e default to "not valid" so that any path other than a live capture
    // or an un-acknowledged HOLD presents zeros with the enable deasserted.
    always_comb begin
        snap_d = snap_q;
        cnt_d  = cnt_q;
        w_d    = '0;
        e_d    = 1'b1;
        err_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!w_ks_zero) begin
                    snap_d = w_ks;
                    cnt_d  = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (w_ks_zero) begin
                    // Abandon the press; IDLE reloads snap and cnt on entry.
                    snap_d = snap_q;
                end else if (!w_ks_match) begin
                    // Pattern moved: restart the stability window on it.
                    snap_d = w_ks;
                    cnt_d  = '0;
                end else if (!w_cnt_done) begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end else if (w_snap_onehot) begin
                    w_d = snap_q;
                    e_d = 1'b0;
                end else begin
                    // Rejected chord: the release window starts from zero so
                    // the full all-zero interval is required before re-arming.
                    err_d = 1'b1;
                    cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (ack) begin
                    cnt_d = '0;
                end else begin
                    w_d = w_q;
                    e_d = e_q;
                end
            end
            ST_RELEASE: begin
                if (!w_ks_zero) begin
                    cnt_d = '0;
                end else if (!w_cnt_done) begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            cnt_q  <= '0;
            w_q    <= '0;
            e_q    <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
            w_q    <= w_d;
            e_q    <= e_d;
            err_q  <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign w   = w_q;
    assign e   = e_q;
    assign err = err_q;

endmodule : onehot_key_capture
`default_nettype wire

// File: tb/tb_onehot_key_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_key_capture
//  Description : Directed self-checking bench for onehot_key_capture with
//                WIDTH=8, DEBOUNCE_CYCLES=4. Inputs change 1 ns after a
//                rising edge; outputs are sampled at the same point.
//                From a key change, a capture shows on e/w after the 7th
//                rising edge (2 synchroniser + 4 stable + 1 capture).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_key_capture;

    localparam int c_WIDTH = 8;
    localparam int c_DEB   = 4;

    logic               clk;
    logic               rst_n;
    logic [c_WIDTH-1:0] key_in;
    logic               ack;
    logic [c_WIDTH-1:0] w;
    logic               e;
    logic               err;

    int total;
    int bad;

    onehot_key_capture #(
        .WIDTH           (c_WIDTH),
        .DEBOUNCE_CYCLES (c_DEB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .ack    (ack),
        .w      (w),
        .e      (e),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = '0;
        ack    = 1'b0;
        repeat (3) tick();
        total++;
        if (w !== 8'h00 || e !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: w=%h e=%b err=%b, want w=00 e=1 err=0", w, e, err);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (w !== 8'h00 || e !== 1'b1 || err !== 1'b0) begin
                bad++;
                $display("FAIL idle[%0d]: w=%h e=%b err=%b, want w=00 e=1 err=0", i, w, e, err);
            end
        end
    endtask

    task automatic test_clean_press();
        key_in = 8'h10;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total++;
            if (i < 7) begin
                if (e !== 1'b1 || w !== 8'h00) begin
                    bad++;
                    $display("FAIL clean_wait[%0d]: e=%b w=%h, want e=1 w=00", i, e, w);
                end
            end else if (e !== 1'b0 || w !== 8'h10) begin
                bad++;
                $display("FAIL clean_capture: e=%b w=%h, want e=0 w=10", e, w);
            end
        end
        repeat (3) tick();
        total++;
        if (e !== 1'b0 || w !== 8'h10) begin
            bad++;
            $display("FAIL clean_hold: e=%b w=%h, want e=0 w=10", e, w);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (e !== 1'b1 || w !== 8'h00) begin
            bad++;
            $display("FAIL clean_ack: e=%b w=%h, want e=1 w=00", e, w);
        end
        // Key still held: must not recapture.
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (e !== 1'b1) begin
                bad++;
                $display("FAIL clean_no_recapture[%0d]: e=%b, want 1", i, e);
            end
        end
        key_in = '0;
        repeat (8) tick();
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 10; t++) begin
            key_in = (((t / 2) % 2) == 1) ? 8'h04 : 8'h00;
            tick();
            total++;
            if (e !== 1'b1 || w !== 8'h00) begin
                bad++;
                $display("FAIL bounce_toggle[%0d]: e=%b w=%h, want e=1 w=00", t, e, w);
            end
        end
        key_in = 8'h04;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total++;
            if (i < 7) begin
                if (e !== 1'b1) begin
                    bad++;
                    $display("FAIL bounce_wait[%0d]: e=%b, want 1", i, e);
                end
            end else if (e !== 1'b0 || w !== 8'h04) begin
                bad++;
                $display("FAIL bounce_capture: e=%b w=%h, want e=0 w=04", e, w);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        key_in = '0;
        repeat (8) tick();
    endtask

    task automatic test_multi_key();
        key_in = 8'h81;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (e !== 1'b1 || w !== 8'h00 || err !== (i == 7)) begin
                bad++;
                $display("FAIL multi_err[%0d]: e=%b w=%h err=%b, want e=1 w=00 err=%b",
                         i, e, w, err, (i == 7));
            end
        end
        // Only three clear clocks: release window must restart.
        key_in = '0;
        repeat (3) tick();
        key_in = 8'h08;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (e !== 1'b1 || err !== 1'b0) begin
                bad++;
                $display("FAIL multi_short_release[%0d]: e=%b err=%b, want e=1 err=0", i, e, err);
            end
        end
        // Exactly four clear clocks: the next press is accepted.
        key_in = '0;
        repeat (4) tick();
        key_in = 8'h08;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total++;
            if (i < 7) begin
                if (e !== 1'b1) begin
                    bad++;
                    $display("FAIL multi_rearm_wait[%0d]: e=%b, want 1", i, e);
                end
            end else if (e !== 1'b0 || w !== 8'h08) begin
                bad++;
                $display("FAIL multi_rearm_capture: e=%b w=%h, want e=0 w=08", e, w);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        key_in = '0;
        repeat (8) tick();
    endtask

    task automatic test_hold();
        key_in = 8'h02;
        repeat (7) tick();
        total++;
        if (e !== 1'b0 || w !== 8'h02) begin
            bad++;
            $display("FAIL hold_capture: e=%b w=%h, want e=0 w=02", e, w);
        end
        key_in = 8'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (e !== 1'b0 || w !== 8'h02) begin
                bad++;
                $display("FAIL hold_frozen[%0d]: e=%b w=%h, want e=0 w=02", i, e, w);
            end
        end
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (e !== 1'b1 || w !== 8'h00 || err !== 1'b0) begin
                bad++;
                $display("FAIL hold_ack_long[%0d]: e=%b w=%h err=%b, want e=1 w=00 err=0", i, e, w, err);
            end
        end
        ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (e !== 1'b1) begin
                bad++;
                $display("FAIL hold_still_pressed[%0d]: e=%b, want 1", i, e);
            end
        end
        key_in = '0;
        repeat (3) tick();
        key_in = 8'h40;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (e !== 1'b1) begin
                bad++;
                $display("FAIL hold_short_release[%0d]: e=%b, want 1", i, e);
            end
        end
        key_in = '0;
        repeat (4) tick();
        key_in = 8'h20;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total++;
            if (i < 7) begin
                if (e !== 1'b1) begin
                    bad++;
                    $display("FAIL hold_rearm_wait[%0d]: e=%b, want 1", i, e);
                end
            end else if (e !== 1'b0 || w !== 8'h20) begin
                bad++;
                $display("FAIL hold_rearm_capture: e=%b w=%h, want e=0 w=20", e, w);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        key_in = '0;
        repeat (8) tick();
    endtask

    task automatic test_async_reset();
        key_in = 8'h01;
        repeat (7) tick();
        total++;
        if (e !== 1'b0 || w !== 8'h01) begin
            bad++;
            $display("FAIL areset_capture: e=%b w=%h, want e=0 w=01", e, w);
        end
        key_in = '0;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (e !== 1'b1 || w !== 8'h00 || err !== 1'b0) begin
            bad++;
            $display("FAIL areset_immediate: e=%b w=%h err=%b, want e=1 w=00 err=0", e, w, err);
        end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (e !== 1'b1 || w !== 8'h00) begin
            bad++;
            $display("FAIL areset_after: e=%b w=%h, want e=1 w=00", e, w);
        end
        key_in = 8'h80;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total++;
            if (i < 7) begin
                if (e !== 1'b1) begin
                    bad++;
                    $display("FAIL areset_press_wait[%0d]: e=%b, want 1", i, e);
                end
            end else if (e !== 1'b0 || w !== 8'h80) begin
                bad++;
                $display("FAIL areset_press_capture: e=%b w=%h, want e=0 w=80", e, w);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (e !== 1'b1 || w !== 8'h00) begin
            bad++;
            $display("FAIL areset_ack: e=%b w=%h, want e=1 w=00", e, w);
        end
        key_in = '0;
        repeat (8) tick();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        key_in = '0;
        ack    = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_onehot_key_capture
`default_nettype wire

// File: doc/onehot_key_capture.md
# onehot_key_capture

- Upstream stage of the 8-to-3 encoder with enable.
- Takes eight raw, asynchronous key/request lines, synchronises and debounces them, and checks that exactly one line is active.
- Presents a stable one-hot word `w` with an active-low enable `e` that drive the encoder directly.
- Holds the word until the consumer acknowledges, then waits for all keys to be released before accepting the next press.

## Interface
Parameters:
- `WIDTH`, 8, number of key lines; width of `w`.
- `DEBOUNCE_CYCLES`, 16, consecutive stable clocks required; legal range ≥ 2.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, reset; asynchronous assert, active-low.
- `key_in`, input, WIDTH, raw asynchronous key lines, active-high.
- `ack`, input, 1, consumer has taken the current code; sampled only in HOLD.
- `w`, output, WIDTH, captured one-hot word; all zeros when not valid.
- `e`, output, 1, active-low valid. 0 means `w` holds a valid one-hot word, which matches the encoder's enable sense.
- `err`, output, 1, one-clock pulse when a debounced pattern with more than one bit set is rejected.

## Operation
- `key_in` passes through a 2-flop synchroniser per bit, giving `ks`. Only `ks` is used by the state machine.
- Internal registers:
  - `snap`: last sampled pattern.
  - `cnt`: counter of width $clog2(DEBOUNCE_CYCLES).
- **IDLE**
  - `ks` == 0: stay.
  - Otherwise: `snap` ← `ks`, `cnt` ← 0, go to DEBOUNCE.
- **DEBOUNCE**
  - `ks` == 0: go to IDLE.
  - `ks` ≠ `snap`: `snap` ← `ks`, `cnt` ← 0 (restart).
  - `ks` == `snap` and `cnt` < DEBOUNCE_CYCLES-1: `cnt`++.
  - `ks` == `snap` and `cnt` == DEBOUNCE_CYCLES-1:
    - `snap` one-hot: `w` ← `snap`, `e` ← 0, go to HOLD.
    - Otherwise: `err` ← 1 for one clock, go to RELEASE.
- **HOLD**
  - `w` and `e` stay frozen. Changes on `ks` are ignored.
  - `ack` = 1: `w` ← 0, `e` ← 1, `cnt` ← 0, go to RELEASE.
- **RELEASE**
  - `ks` ≠ 0: `cnt` ← 0.
  - Otherwise `cnt`++.
  - `cnt` == DEBOUNCE_CYCLES-1 with `ks` == 0: go to IDLE.
- Outside HOLD, `w` is always 0 and `e` always 1. The encoder therefore never sees an undefined pattern while enabled.

## Timing
- Reset values: `w` = 0, `e` = 1, `err` = 0, state IDLE, `snap` = 0, `cnt` = 0, synchroniser flops 0.
- Reset asserted mid-operation returns all of the above immediately; any HOLD code is discarded.
- Latency: let `ks` first show a stable nonzero pattern in clock T. Then `e` falls after the edge ending clock T+DEBOUNCE_CYCLES. Counting from raw `key_in`, add 2 clocks for the synchroniser.
- `ack` sampled high in HOLD: `e` = 1 and `w` = 0 from the next clock.
  - `ack` held high for many clocks produces exactly one release.
  - `ack` outside HOLD is ignored.
- `ack` arriving in the same clock as a `ks` change in HOLD: `ack` wins.
- `err` is high for exactly one clock, coincident with the DEBOUNCE→RELEASE transition. `e` stays 1 throughout.
- After a release, the next capture needs at least DEBOUNCE_CYCLES clocks of all-zero `ks` before IDLE can be re-entered.
- `cnt` saturates at its terminal compare and never wraps.

## Structure
- Shared package `key_capture_pkg` contains:
  - State enum: IDLE, DEBOUNCE, HOLD, RELEASE.
  - Function `is_onehot(WIDTH-bit)`, true iff exactly one bit is set; all-zero returns false.
- Sub-module `key_sync`: WIDTH-wide 2-flop synchroniser with asynchronous active-low reset to 0.
- Top-level `onehot_key_capture` instantiates `key_sync`, the FSM and the counter.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- Reset then idle: `key_in` = 0 for 20 clocks → `w` = 0, `e` = 1, `err` = 0 throughout.
- Clean press: `key_in` = 8'h10 held → `e` low exactly 2+4 clocks after the first sampling edge, `w` = 8'h10. `ack` pulse → `e` = 1 and `w` = 0 next clock.
- Bounce: `key_in` toggles 8'h04/0 every 2 clocks for 10 clocks, then holds 8'h04 → no `e` low during toggling; capture 8'h04 with full latency after it stabilises.
- Multi-key: `key_in` = 8'h81 stable → `err` one-clock pulse, `e` stays 1. Next capture only after 4 clocks of all-zero.
- Hold behaviour: in HOLD with 8'h02, switch `key_in` to 8'h40 → `w` stays 8'h02. Keep `ack` high 5 clocks → single release, no recapture until keys are released for 4 clocks.
- Asynchronous reset asserted mid-HOLD (not clock-aligned) → `e` = 1 and `w` = 0 immediately. After deassert, state is IDLE and a new press completes normally.
